csa_job_gen: RTL and testbench

- Upstream producer for the CSA input FIFO: splits a configured key-search range into fixed-size jobs.
- Writes each job as a 5-word record into the FIFO that the CSA RAM/dispatch stage drains.
- Record word order: block, in_lo, in_hi, times, times_start. This is exactly the order the dispatch stage consumes.
- Software loads the configuration, pulses start, and polls busy/done/jobs_issued.

---
 rtl/csa_pkg.sv | 31 +++
 rtl/csa_job_gen.sv | 122 ++++++++++++
 tb/tb_csa_job_gen.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Definitions shared by the CSA job generator and the CSA RAM/dispatch stage.
// Record layout, padded calc-input width and generator state encoding.
package csa_pkg;

    localparam int unsigned RECORD_WORDS    = 5;

    // Word positions inside one job record, in FIFO write order.
    localparam int unsigned REC_BLOCK       = 0;
    localparam int unsigned REC_IN_LO       = 1;
    localparam int unsigned REC_IN_HI       = 2;
    localparam int unsigned REC_TIMES       = 3;
    localparam int unsigned REC_TIMES_START = 4;

    // The calc input travels as two full FIFO words, upper bits zero-padded.
    function automatic int unsigned csa_calc_in_width_pad(input int unsigned axi_width);
        return 2 * axi_width;
    endfunction

    localparam int unsigned CSA_CALC_IN_WIDTH_PAD = csa_calc_in_width_pad(32);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        W1,
        W2,
        W3,
        W4,
        ADV
    } job_state_e;

endpackage

// File: rtl/csa_job_gen.sv
// Splits a configured key-search range into fixed-size jobs and writes each
// job as a 5-word record into the CSA input FIFO.
module csa_job_gen
    import csa_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH    = 32,
    parameter int unsigned CSA_CALC_IN_WIDTH = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AXI_DATA_WIDTH-1:0]    cfg_block,
    input  logic [CSA_CALC_IN_WIDTH-1:0] cfg_in,
    input  logic [AXI_DATA_WIDTH-1:0]    cfg_times_start,
    input  logic [AXI_DATA_WIDTH-1:0]    cfg_total,
    input  logic [AXI_DATA_WIDTH-1:0]    cfg_chunk,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic [AXI_DATA_WIDTH-1:0]    jobs_issued,
    input  logic                         csa_in_full,
    output logic                         csa_in_wen,
    output logic [AXI_DATA_WIDTH-1:0]    csa_in_wdata
);

    localparam int unsigned AW    = AXI_DATA_WIDTH;
    localparam int unsigned PAD_W = csa_calc_in_width_pad(AXI_DATA_WIDTH);

    job_state_e         state;
    logic [AW-1:0]      blk_r;
    logic [PAD_W-1:0]   in_r;
    logic [AW-1:0]      remaining;
    logic [AW-1:0]      cur;
    logic [AW-1:0]      chunk;
    logic [AW-1:0]      count;
    logic               abort_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            blk_r         <= '0;
            in_r          <= '0;
            remaining     <= '0;
            cur           <= '0;
            chunk         <= '0;
            count         <= '0;
            abort_pending <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            jobs_issued   <= '0;
            csa_in_wen    <= 1'b0;
            csa_in_wdata  <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            // Abort is only latched here; CHECK acts on it so records stay whole.
            if (state != IDLE && abort)
                abort_pending <= 1'b1;

            case (state)
                IDLE: begin
                    csa_in_wen <= 1'b0;
                    if (start) begin
                        blk_r         <= cfg_block;
                        in_r          <= PAD_W'(cfg_in);
                        remaining     <= cfg_total;
                        cur           <= cfg_times_start;
                        chunk         <= (cfg_chunk == '0) ? AW'(1) : cfg_chunk;
                        jobs_issued   <= '0;
                        abort_pending <= 1'b0;
                        busy          <= 1'b1;
                        state         <= CHECK;
                    end
                end
                CHECK: begin
                    if (remaining == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (abort_pending) begin
                        aborted       <= 1'b1;
                        busy          <= 1'b0;
                        abort_pending <= 1'b0;
                        state         <= IDLE;
                    end else if (!csa_in_full) begin
                        count        <= (chunk < remaining) ? chunk : remaining;
                        csa_in_wen   <= 1'b1;
                        csa_in_wdata <= blk_r;
                        state        <= W1;
                    end
                end
                W1: begin
                    csa_in_wdata <= in_r[AW-1:0];
                    state        <= W2;
                end
                W2: begin
                    csa_in_wdata <= in_r[PAD_W-1:AW];
                    state        <= W3;
                end
                W3: begin
                    csa_in_wdata <= count;
                    state        <= W4;
                end
                W4: begin
                    csa_in_wdata <= cur;
                    state        <= ADV;
                end
                ADV: begin
                    csa_in_wen  <= 1'b0;
                    cur         <= cur + count;
                    remaining   <= remaining - count;
                    jobs_issued <= jobs_issued + AW'(1);
                    state       <= CHECK;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_job_gen.sv
// Self-checking bench for csa_job_gen: directed cases plus randomized ranges
// compared against a record-list model of the job splitting.
module tb_csa_job_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_block;
    logic [47:0] cfg_in;
    logic [31:0] cfg_times_start;
    logic [31:0] cfg_total;
    logic [31:0] cfg_chunk;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] jobs_issued;
    logic        csa_in_full;
    logic        csa_in_wen;
    logic [31:0] csa_in_wdata;

    always #5 clk = ~clk;

    csa_job_gen #(
        .AXI_DATA_WIDTH   (32),
        .CSA_CALC_IN_WIDTH(48)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_block      (cfg_block),
        .cfg_in         (cfg_in),
        .cfg_times_start(cfg_times_start),
        .cfg_total      (cfg_total),
        .cfg_chunk      (cfg_chunk),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .jobs_issued    (jobs_issued),
        .csa_in_full    (csa_in_full),
        .csa_in_wen     (csa_in_wen),
        .csa_in_wdata   (csa_in_wdata)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int          exp_jobs;
    int          done_total = 0;
    int          abort_total = 0;
    int          run_len = 0;
    bit          rand_full = 1'b0;

    // Monitor: collects written words, checks records are 5-word bursts.
    always @(negedge clk) begin
        if (!rst) begin
            if (csa_in_wen) begin
                got.push_back(csa_in_wdata);
                run_len++;
            end else if (run_len != 0) begin
                checks++;
                assert (run_len === 5) else begin
                    failures++;
                    $error("FAIL record_burst observed=%0d expected=5", run_len);
                end
                run_len = 0;
            end
            if (done) done_total++;
            if (aborted) abort_total++;
            checks++;
            assert (!(done && aborted)) else begin
                failures++;
                $error("FAIL done_aborted_exclusive observed=1 expected=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected word stream: ceil-divide the range into jobs of at most chunk.
    function automatic void model(input logic [31:0] blk, input logic [47:0] in_v,
                                  input logic [31:0] ts, input logic [31:0] total,
                                  input logic [31:0] chunk, input int max_recs);
        longint rem, ch, c, cur_v;
        exp_q.delete();
        exp_jobs = 0;
        rem   = total;
        ch    = (chunk == 0) ? 1 : chunk;
        cur_v = ts;
        while (rem > 0 && exp_jobs < max_recs) begin
            c = (rem < ch) ? rem : ch;
            exp_q.push_back(blk);
            exp_q.push_back(in_v[31:0]);
            exp_q.push_back(32'(in_v >> 32));
            exp_q.push_back(32'(c));
            exp_q.push_back(32'(cur_v));
            cur_v = (cur_v + c) % 64'h1_0000_0000;
            rem   = rem - c;
            exp_jobs++;
        end
    endfunction

    task automatic compare_stream(input string name);
        chk({name, "_nwords"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_word%0d", name, i), got[i], exp_q[i]);
        chk({name, "_jobs_issued"}, jobs_issued, exp_jobs);
    endtask

    task automatic set_cfg(input logic [31:0] blk, input logic [47:0] in_v,
                           input logic [31:0] ts, input logic [31:0] total,
                           input logic [31:0] chunk);
        cfg_block = blk;
        cfg_in = in_v;
        cfg_times_start = ts;
        cfg_total = total;
        cfg_chunk = chunk;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Waits for busy to fall, then checks which terminal pulse came with it.
    task automatic wait_end(input string name, input bit exp_done, input bit scramble);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (rand_full) csa_in_full = ($urandom_range(0, 3) == 0);
            if (scramble && i == 2) begin
                start = 1'b1;
                set_cfg($urandom, {$urandom, $urandom}, $urandom, $urandom, $urandom);
            end
            if (scramble && i == 3) start = 1'b0;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        csa_in_full = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout observed=busy expected=idle", name);
        end
        chk({name, "_done"}, done, exp_done);
        chk({name, "_aborted"}, aborted, !exp_done);
        @(posedge clk); #1;
        chk({name, "_pulse_width"}, {done, aborted}, 2'b00);
    endtask

    initial begin
        int d0, a0, wen_seen;
        logic [31:0] r_blk, r_ts, r_tot, r_ch;
        logic [47:0] r_in;

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        csa_in_full = 1'b0;
        set_cfg(32'h0, 48'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_aborted", aborted, 1'b0);
        chk("rst_jobs", jobs_issued, 32'h0);
        chk("rst_wen", csa_in_wen, 1'b0);
        chk("rst_wdata", csa_in_wdata, 32'h0);
        rst = 1'b0;

        // Basic split with first-write latency.
        set_cfg(32'hDEADBEEF, 48'hA1B2_C3D4_E5F6, 32'd100, 32'd10, 32'd4);
        model(cfg_block, cfg_in, cfg_times_start, cfg_total, cfg_chunk, 1000);
        got.delete(); d0 = done_total; a0 = abort_total;
        pulse_start();
        chk("basic_busy", busy, 1'b1);
        @(posedge clk); #1;
        chk("basic_first_wen", csa_in_wen, 1'b1);
        chk("basic_first_word", csa_in_wdata, 32'hDEADBEEF);
        wait_end("basic", 1'b1, 1'b0);
        compare_stream("basic");
        chk("basic_in_lo", got.size() > 2 ? got[1] : 32'hx, 32'hC3D4E5F6);
        chk("basic_in_hi", got.size() > 2 ? got[2] : 32'hx, 32'h0000A1B2);
        chk("basic_last_times", got.size() > 14 ? got[13] : 32'hx, 32'd2);
        chk("basic_last_start", got.size() > 14 ? got[14] : 32'hx, 32'd108);
        chk("basic_done_count", done_total - d0, 1);
        chk("basic_abort_count", abort_total - a0, 0);

        // FIFO full holds the generator in CHECK.
        got.delete();
        csa_in_full = 1'b1;
        pulse_start();
        wen_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (csa_in_wen) wen_seen++;
        end
        chk("full_no_wen", wen_seen, 0);
        chk("full_busy", busy, 1'b1);
        csa_in_full = 1'b0;
        @(posedge clk); #1;
        chk("full_release_wen", csa_in_wen, 1'b1);
        chk("full_release_word", csa_in_wdata, 32'hDEADBEEF);
        wait_end("full", 1'b1, 1'b0);
        compare_stream("full");

        // Empty range: done two cycles after start, no writes.
        set_cfg(32'h1, 48'h2, 32'h3, 32'd0, 32'd5);
        got.delete();
        pulse_start();
        @(posedge clk); #1;
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_wen", csa_in_wen, 1'b0);
        chk("zero_jobs", jobs_issued, 32'h0);
        @(posedge clk); #1;
        chk("zero_nwords", got.size(), 0);

        // Chunk of zero acts as one.
        set_cfg(32'h11112222, 48'h0000_3333_4444, 32'd7, 32'd2, 32'd0);
        model(cfg_block, cfg_in, cfg_times_start, cfg_total, cfg_chunk, 1000);
        got.delete();
        pulse_start();
        wait_end("chunk0", 1'b1, 1'b0);
        compare_stream("chunk0");

        // Iteration index wraps past 2^32.
        set_cfg(32'hCAFEF00D, 48'hFFFF_0000_FFFF, 32'hFFFFFFFE, 32'd4, 32'd3);
        model(cfg_block, cfg_in, cfg_times_start, cfg_total, cfg_chunk, 1000);
        got.delete();
        pulse_start();
        wait_end("wrap", 1'b1, 1'b0);
        compare_stream("wrap");
        chk("wrap_second_start", got.size() > 9 ? got[9] : 32'hx, 32'h00000001);

        // Abort during W2 of the first record.
        set_cfg(32'h0BADF00D, 48'h1234_5678_9ABC, 32'd0, 32'd100, 32'd10);
        model(cfg_block, cfg_in, cfg_times_start, cfg_total, cfg_chunk, 1);
        got.delete(); d0 = done_total; a0 = abort_total;
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_end("abort", 1'b0, 1'b0);
        compare_stream("abort");
        chk("abort_done_count", done_total - d0, 0);
        chk("abort_abort_count", abort_total - a0, 1);

        // Abort landing with the last ADV: done wins.
        set_cfg(32'h55, 48'h66, 32'd9, 32'd4, 32'd4);
        model(cfg_block, cfg_in, cfg_times_start, cfg_total, cfg_chunk, 1000);
        got.delete(); d0 = done_total; a0 = abort_total;
        pulse_start();
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_end("abort_last", 1'b1, 1'b0);
        compare_stream("abort_last");
        chk("abort_last_abort_count", abort_total - a0, 0);

        // Abort while idle is ignored; restart after abort runs normally.
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        set_cfg(32'h77, 48'h8888_9999_AAAA, 32'd50, 32'd7, 32'd3);
        model(cfg_block, cfg_in, cfg_times_start, cfg_total, cfg_chunk, 1000);
        got.delete();
        pulse_start();
        wait_end("restart", 1'b1, 1'b0);
        compare_stream("restart");

        // Random ranges with random back-pressure, cfg changes and start while busy.
        for (int n = 0; n < 6; n++) begin
            r_blk = $urandom;
            r_in  = {$urandom, $urandom};
            r_ts  = (n == 0) ? 32'hFFFFFFF0 : $urandom;
            r_tot = $urandom_range(5, 30);
            r_ch  = $urandom_range(0, 7);
            set_cfg(r_blk, r_in, r_ts, r_tot, r_ch);
            model(r_blk, r_in, r_ts, r_tot, r_ch, 1000);
            got.delete();
            rand_full = 1'b1;
            pulse_start();
            wait_end($sformatf("rand%0d", n), 1'b1, 1'b1);
            rand_full = 1'b0;
            compare_stream($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
